// File: rtl/rng_pkg.sv
// Shared constants, state encoding and FIFO word layout for the RNG index sampler path.
package rng_pkg;

  localparam int unsigned R_DEFAULT  = 10163;
  localparam int unsigned H_DAT_W    = 14;
  localparam int unsigned HALF_W     = 16;
  localparam int unsigned SRC_W      = 32;
  localparam int unsigned RNG_DAT_W  = 64;
  localparam int unsigned REJ_W      = 16;
  localparam int unsigned SLOT_A_LSB = 0;
  localparam int unsigned SLOT_B_LSB = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SPLIT = 2'd2;
  localparam logic [1:0] ST_PUSH  = 2'd3;

  // Layout read by the h0/h1 generators: A in [13:0], B in [29:16], rest zero.
  typedef struct packed {
    logic [RNG_DAT_W-SLOT_B_LSB-H_DAT_W-1:0] pad_hi;
    logic [H_DAT_W-1:0]                      idx_b;
    logic [SLOT_B_LSB-SLOT_A_LSB-H_DAT_W-1:0] pad_lo;
    logic [H_DAT_W-1:0]                      idx_a;
  } rng_word_t;

  function automatic logic [RNG_DAT_W-1:0] pack_pair(input logic [H_DAT_W-1:0] a,
                                                     input logic [H_DAT_W-1:0] b);
    rng_word_t w;
    w       = '0;
    w.idx_a = a;
    w.idx_b = b;
    return w;
  endfunction

endpackage

// File: rtl/idx_reject_cmp.sv
// Candidate acceptance: c < R, plus an optional A==B rejection when
// RNG_SAMPLER_PAIR_DEDUP_EN is defined.
module idx_reject_cmp
  import rng_pkg::*;
#(
  parameter int unsigned R = R_DEFAULT
) (
  input  logic [H_DAT_W-1:0] cand,
  input  logic [H_DAT_W-1:0] slot_a,
  input  logic               dup_chk,
  output logic               accept_c
);

  logic below_r_c;
  assign below_r_c = 32'(cand) < R;

`ifdef RNG_SAMPLER_PAIR_DEDUP_EN
  assign accept_c = below_r_c && !(dup_chk && (cand == slot_a));
`else
  logic unused_dup;
  assign unused_dup = ^{slot_a, dup_chk};
  assign accept_c   = below_r_c;
`endif

endmodule

// File: rtl/rng_idx_sampler.sv
// Rejection-samples 14-bit indices below r from 32-bit entropy words and packs
// pairs into 64-bit RNG FIFO words. Optional pair dedup: RNG_SAMPLER_PAIR_DEDUP_EN.
module rng_idx_sampler
  import rng_pkg::*;
#(
  parameter int unsigned r = R_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [1:0]           rng_start,
  input  logic                 fifo_rng_wr,
  input  logic                 src_valid,
  input  logic [SRC_W-1:0]     src_data,
  output logic                 src_ready,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [RNG_DAT_W-1:0] fifo_dout,
  output logic [REJ_W-1:0]     rej_cnt
);

  logic [1:0]           state_q, state_nxt;
  logic [2*H_DAT_W-1:0] word_q;
  logic                 half_q;
  logic                 slot_q;
  logic                 pend_q;
  logic [H_DAT_W-1:0]   idx_a_q, idx_b_q;

  logic               run_c;
  logic               push_ok_c;
  logic               accept_c;
  logic [H_DAT_W-1:0] cand_c;
  logic               unused_src;

  assign run_c      = |rng_start;
  assign push_ok_c  = fifo_rng_wr && !fifo_full;
  assign cand_c     = half_q ? word_q[2*H_DAT_W-1:H_DAT_W] : word_q[H_DAT_W-1:0];
  assign src_ready  = (state_q == ST_FETCH);
  assign unused_src = ^{src_data[SRC_W-1:HALF_W+H_DAT_W], src_data[HALF_W-1:H_DAT_W]};

  idx_reject_cmp #(.R(r)) u_cmp (
    .cand     (cand_c),
    .slot_a   (idx_a_q),
    .dup_chk  (slot_q),
    .accept_c (accept_c)
  );

  always_ff @(posedge clk) begin
    if (rst_b) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (!run_c) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_nxt = ST_FETCH;
        ST_FETCH: if (src_valid) state_nxt = ST_SPLIT;
        ST_SPLIT: begin
          if (accept_c && slot_q) state_nxt = ST_PUSH;
          else if (half_q)        state_nxt = ST_FETCH;
        end
        ST_PUSH:  if (push_ok_c) state_nxt = pend_q ? ST_SPLIT : ST_FETCH;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Pack register, write strobe and reject counter; a stop request discards the partial pack.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      word_q     <= '0;
      half_q     <= 1'b0;
      slot_q     <= 1'b0;
      pend_q     <= 1'b0;
      idx_a_q    <= '0;
      idx_b_q    <= '0;
      fifo_wr_en <= 1'b0;
      fifo_dout  <= '0;
      rej_cnt    <= '0;
    end else begin
      fifo_wr_en <= 1'b0;
      if (!run_c) begin
        word_q  <= '0;
        half_q  <= 1'b0;
        slot_q  <= 1'b0;
        pend_q  <= 1'b0;
        idx_a_q <= '0;
        idx_b_q <= '0;
      end else begin
        case (state_q)
          ST_FETCH: begin
            if (src_valid) begin
              word_q <= {src_data[HALF_W +: H_DAT_W], src_data[0 +: H_DAT_W]};
              half_q <= 1'b0;
            end
          end
          ST_SPLIT: begin
            if (accept_c) begin
              if (slot_q) idx_b_q <= cand_c;
              else        idx_a_q <= cand_c;
              slot_q <= ~slot_q;
            end else if (rej_cnt != {REJ_W{1'b1}}) begin
              rej_cnt <= rej_cnt + REJ_W'(1);
            end
            half_q <= 1'b1;
            pend_q <= accept_c && slot_q && !half_q;
          end
          ST_PUSH: begin
            if (push_ok_c) begin
              fifo_wr_en <= 1'b1;
              fifo_dout  <= pack_pair(idx_a_q, idx_b_q);
              idx_a_q    <= '0;
              idx_b_q    <= '0;
              slot_q     <= 1'b0;
              pend_q     <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
